ustc_sparse_core: RTL and testbench
===================================

# ustc_sparse_core

Unstructured-sparse tensor-core datapath: multiplies a sparse A matrix, given as a list of (value, row, col) nonzero entries, by a dense K×N B matrix. The block sits between the operand staging buffers and the result writeback path. It loads both operands in one cycle, runs a fixed-rate MAC sweep over a programmable number of nonzero blocks, then streams the M×N result one row per cycle.

## Interface
- M, 16: rows of A / C.
- N, 16: columns of B / C.
- K, 16: inner dimension.
- tileN, 1: column tiles; iterN = N/tileN columns per pass.
- tileK, 8: cycles per block.
- iterN, 16: output columns per MAC group.
- iterK, 2: A entries consumed per cycle.
- N_UNIT, 32: multipliers, = iterK*iterN.
- DW_DATA, 8: operand/result width.
- DW_ROW, 4: row index width.
- DW_COL, 4: col index width.
- DW_CTRL, 4: per-entry control width.
- DW_A, DW_DATA+DW_ROW+DW_COL: A entry width.
- DW_B, DW_DATA: B element width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_en  in  1  capture operands.
- compute_en  in  1  run/hold enable (level).
- in_a  in  M*K*DW_A  entry e at [e*DW_A +: DW_A]; fields {value[15:8], row[7:4], col[3:0]} (MSB→LSB).
- in_a_ctrl  in  M*K*DW_CTRL  ctrl e at [e*DW_CTRL +: DW_CTRL]; bit0 = valid, bits[3:1] ignored.
- in_b  in  N*K*DW_B  B(k,n) at [(n*K+k)*DW_B +: DW_B] (column-major).
- num_blocks  in  4  number of 16-entry blocks to process (0–15).
- out  out  N*DW_DATA  result row; C(r,n) at [n*DW_DATA +: DW_DATA]; reset 0.

## Operation
- FSM: IDLE, COMPUTE, DRAIN, DONE. Reset → IDLE, accumulators 0, buffers 0, out 0.
- IDLE: load_en=1 registers in_a, in_a_ctrl, in_b into internal buffers. Each high cycle overwrites them, so the last one wins. load_en is ignored in all other states.
- IDLE with compute_en=1 and load_en=0 → COMPUTE. Accumulators and the entry pointer are cleared on entry. num_blocks is latched at entry.
- COMPUTE, per cycle with compute_en=1:
  - Consume entries e = 2p and 2p+1.
  - For each entry with valid=1: acc[row][n] += value × B(col,n) for all n.
  - If both entries target the same row, both products are summed in the same cycle.
  - Pointer advances by 2.
- COMPUTE with compute_en=0: hold, no accumulation, pointer unchanged.
- COMPUTE ends after num_blocks*tileK cycles (num_blocks*16 entries) → DRAIN.
- num_blocks=0 goes straight to DRAIN with all-zero accumulators.
- Arithmetic:
  - value and B are signed 8-bit two's complement; product is 16-bit signed.
  - acc is 24-bit signed (cannot overflow for ≤240 entries).
  - Output element = acc saturated to [-128, 127].
- DRAIN:
  - out ← saturated row r for r = 0..M-1, one row per cycle, independent of compute_en.
  - After row M-1 → DONE.
- DONE: out holds row M-1. compute_en=0 → IDLE. out keeps its value until the next DRAIN or reset.
- Entries beyond the processed range are never read.
- row/col fields index 0..15 directly.

## Timing
- Load: buffers are valid the cycle after the load_en edge.
- Compute: first MAC at the first edge in COMPUTE. Accumulation is one cycle per entry pair.
- Result latency from COMPUTE entry: num_blocks*8 cycles, then row 0 appears on out at the next edge. Row r appears r cycles later.
- With num_blocks=4: 32 compute cycles, rows 0..15 on out over the following 16 cycles.
- Asynchronous reset mid-operation:
  - Immediately clears out, accumulators, pointer and buffers; FSM → IDLE.
  - No partial result is retained.

## Test plan
- Reset: assert reset mid-COMPUTE → out=0 immediately; FSM back in IDLE. A fresh load/compute produces correct results.
- Identity: A entries e=0..15 = {value=1, row=e, col=e, valid=1}; B(k,n)=k+n; num_blocks=1 → out row r holds C(r,n)=r+n, rows 0..15 on 16 consecutive cycles starting 9 cycles after COMPUTE entry.
- Same-row pair: entries 0 and 1 = {3,row2,col0} and {-2,row2,col1}; B(0,n)=5, B(1,n)=4; all others invalid; num_blocks=1 → row2 = 7 in every column; all other rows 0.
- Saturation: 16 entries {127,row0,col0}; B(0,n)=127; num_blocks=1 → row0 = 127 everywhere. Same with B=-127 → row0 = -128.
- Block limit: valid entries in blocks 0..7; num_blocks=4 → only entries 0..63 contribute. num_blocks=0 → all-zero rows after 1 cycle.
- Pause: drop compute_en for 5 cycles mid-COMPUTE → result unchanged; DRAIN starts 5 cycles later.

Source files
------------

// File: rtl/ustc_sparse_core.sv
// ustc_sparse_core: sparse (value,row,col) A times dense K x N B, one entry pair per cycle.
// Ports: clk, reset, load_en, compute_en, in_a, in_a_ctrl, in_b, num_blocks -> out (one C row per cycle).
module ustc_sparse_core #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int K       = 16,
    parameter int tileN   = 1,
    parameter int tileK   = 8,
    parameter int iterN   = 16,
    parameter int iterK   = 2,
    parameter int N_UNIT  = 32,
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_COL  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_A    = DW_DATA + DW_ROW + DW_COL,
    parameter int DW_B    = DW_DATA
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic                      compute_en,
    input  logic [M*K*DW_A-1:0]       in_a,
    input  logic [M*K*DW_CTRL-1:0]    in_a_ctrl,
    input  logic [N*K*DW_B-1:0]       in_b,
    input  logic [3:0]                num_blocks,
    output logic [N*DW_DATA-1:0]      out
);

    localparam int DW_ACC = 24;
    localparam int AW     = $clog2(M*K);
    localparam int DW_MUL = 2*DW_DATA;
    localparam int geom_unused = tileN * N_UNIT;
    localparam logic signed [DW_ACC-1:0] SAT_HI = DW_ACC'((1 << (DW_DATA-1)) - 1);
    localparam logic signed [DW_ACC-1:0] SAT_LO = -DW_ACC'(1 << (DW_DATA-1));

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic   start, mac_en;

    logic [DW_A-1:0]                 a_buf [M*K];
    logic                            a_vld [M*K];
    logic signed [DW_B-1:0]          b_buf [N][K];
    logic signed [DW_ACC-1:0]        acc   [M][N];
    logic signed [DW_ACC-1:0]        acc_inc [M][N];

    logic [6:0]  cyc;
    logic [6:0]  cyc_last;
    logic [3:0]  nb;
    logic [3:0]  drow;

    logic [AW-1:0]               ent_idx [iterK];
    logic                        ent_vld [iterK];
    logic signed [DW_DATA-1:0]   ent_val [iterK];
    logic [DW_ROW-1:0]           ent_row [iterK];
    logic [DW_COL-1:0]           ent_col [iterK];
    logic signed [DW_MUL-1:0]    mul [iterK][iterN];

    logic ctrl_unused;
    assign ctrl_unused = ^in_a_ctrl;

    assign cyc_last = 7'(int'(nb) * tileK) - 7'd1;

    function automatic logic [DW_DATA-1:0] sat(input logic signed [DW_ACC-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[DW_DATA-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DW_DATA-1:0];
        else
            return v[DW_DATA-1:0];
    endfunction

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        mac_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (compute_en && !load_en) begin
                    start    = 1'b1;
                    // an empty job skips the sweep entirely
                    state_nx = (num_blocks == 4'd0) ? DRAIN : COMPUTE;
                end
            end
            COMPUTE: begin
                if (compute_en) begin
                    mac_en = 1'b1;
                    if (cyc == cyc_last)
                        state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drow == 4'(M-1))
                    state_nx = DONE;
            end
            DONE: begin
                if (!compute_en)
                    state_nx = IDLE;
            end
        endcase
    end

    // Entry pair selection and the iterK x iterN multiplier array
    always_comb begin
        for (int j = 0; j < iterK; j++) begin
            ent_idx[j] = AW'(int'(cyc) * iterK + j);
            ent_vld[j] = a_vld[ent_idx[j]];
            ent_val[j] = a_buf[ent_idx[j]][DW_A-1 -: DW_DATA];
            ent_row[j] = a_buf[ent_idx[j]][DW_ROW+DW_COL-1 -: DW_ROW];
            ent_col[j] = a_buf[ent_idx[j]][DW_COL-1:0];
            for (int n = 0; n < iterN; n++)
                mul[j][n] = ent_val[j] * b_buf[n][ent_col[j]];
        end
    end

    // Products steered to their target row; same-row pairs add together
    always_comb begin
        for (int r = 0; r < M; r++) begin
            for (int n = 0; n < N; n++) begin
                acc_inc[r][n] = '0;
                for (int j = 0; j < iterK; j++) begin
                    if (ent_vld[j] && ent_row[j] == DW_ROW'(r))
                        acc_inc[r][n] = acc_inc[r][n]
                            + {{(DW_ACC-DW_MUL){mul[j][n][DW_MUL-1]}}, mul[j][n]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cyc   <= '0;
            nb    <= '0;
            drow  <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                cyc  <= '0;
                nb   <= num_blocks;
                drow <= '0;
            end else if (mac_en) begin
                cyc <= cyc + 7'd1;
            end
            if (state == DRAIN)
                drow <= drow + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < M*K; e++) begin
                a_buf[e] <= '0;
                a_vld[e] <= 1'b0;
            end
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    b_buf[n][k] <= '0;
        end else if (state == IDLE && load_en) begin
            for (int e = 0; e < M*K; e++) begin
                a_buf[e] <= in_a[e*DW_A +: DW_A];
                a_vld[e] <= in_a_ctrl[e*DW_CTRL];
            end
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    b_buf[n][k] <= in_b[(n*K+k)*DW_B +: DW_B];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < M; r++)
                for (int n = 0; n < N; n++)
                    acc[r][n] <= '0;
        end else if (start) begin
            for (int r = 0; r < M; r++)
                for (int n = 0; n < N; n++)
                    acc[r][n] <= '0;
        end else if (mac_en) begin
            for (int r = 0; r < M; r++)
                for (int n = 0; n < N; n++)
                    acc[r][n] <= acc[r][n] + acc_inc[r][n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (state == DRAIN) begin
            for (int n = 0; n < N; n++)
                out[n*DW_DATA +: DW_DATA] <= sat(acc[drow][n]);
        end
    end

endmodule

// File: tb/tb_ustc_sparse_core.sv
// tb_ustc_sparse_core: scoreboard bench for ustc_sparse_core.
// Stimulus queues expected rows with their due edge; a negedge monitor compares them.
module tb_ustc_sparse_core;

    localparam int M = 16;
    localparam int N = 16;
    localparam int K = 16;
    localparam int RW = N*8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_en = 1'b0;
    logic compute_en = 1'b0;
    logic [M*K*16-1:0] in_a = '0;
    logic [M*K*4-1:0]  in_a_ctrl = '0;
    logic [N*K*8-1:0]  in_b = '0;
    logic [3:0]        num_blocks = '0;
    logic [RW-1:0]     out;

    ustc_sparse_core dut (
        .clk(clk),
        .reset(reset),
        .load_en(load_en),
        .compute_en(compute_en),
        .in_a(in_a),
        .in_a_ctrl(in_a_ctrl),
        .in_b(in_b),
        .num_blocks(num_blocks),
        .out(out)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    typedef struct {
        int            due;
        logic [RW-1:0] data;
        string         nm;
    } exp_t;

    exp_t q[$];
    logic [RW-1:0] exp_rows [M];
    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [RW-1:0] got,
                         input logic [RW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            if (q[0].due == edge_n) begin
                check(q[0].nm, out, q[0].data);
                void'(q.pop_front());
            end else if (q[0].due < edge_n) begin
                total++;
                bad++;
                $display("FAIL %s missed due=%0d now=%0d", q[0].nm, q[0].due, edge_n);
                void'(q.pop_front());
            end
        end
    end

    function automatic logic [RW-1:0] row_fill(input int v);
        logic [RW-1:0] x;
        for (int n = 0; n < N; n++) x[n*8 +: 8] = v[7:0];
        return x;
    endfunction

    task automatic clear_ops();
        in_a = '0;
        in_a_ctrl = '0;
        in_b = '0;
    endtask

    task automatic set_a(input int e, input int v, input int r, input int c,
                         input logic [3:0] ctl);
        in_a[e*16 +: 16] = {v[7:0], r[3:0], c[3:0]};
        in_a_ctrl[e*4 +: 4] = ctl;
    endtask

    task automatic set_b(input int k, input int n, input int v);
        in_b[(n*K+k)*8 +: 8] = v[7:0];
    endtask

    task automatic all_rows(input int v);
        for (int r = 0; r < M; r++) exp_rows[r] = row_fill(v);
    endtask

    task automatic setup_identity();
        clear_ops();
        for (int e = 0; e < 16; e++) set_a(e, 1, e, e, (e % 2) ? 4'b1111 : 4'b0001);
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++) set_b(k, n, k + n);
        for (int r = 0; r < M; r++)
            for (int n = 0; n < N; n++) exp_rows[r][n*8 +: 8] = 8'(r + n);
    endtask

    task automatic run_job(input string nm, input bit do_load, input int nb,
                           input int pause_at, input int pause_len);
        int e0;
        int guard;
        exp_t x;
        if (do_load) begin
            @(negedge clk);
            load_en = 1'b1;
        end
        @(negedge clk);
        load_en = 1'b0;
        compute_en = 1'b1;
        num_blocks = 4'(nb);
        e0 = edge_n + 1;
        for (int r = 0; r < M; r++) begin
            x.due = e0 + nb*8 + 1 + r + pause_len;
            x.data = exp_rows[r];
            x.nm = $sformatf("%s_r%0d", nm, r);
            q.push_back(x);
        end
        x.due = e0 + nb*8 + 1 + M + pause_len;
        x.data = exp_rows[M-1];
        x.nm = {nm, "_hold"};
        q.push_back(x);
        if (pause_len > 0) begin
            repeat (1 + pause_at) @(negedge clk);
            compute_en = 1'b0;
            repeat (pause_len) @(negedge clk);
            compute_en = 1'b1;
        end
        guard = 0;
        while (q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout pending=%0d", nm, q.size());
            q.delete();
        end
        @(negedge clk);
        compute_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2;
        check("reset_out", out, '0);
        @(negedge clk);
        reset = 1'b0;

        setup_identity();
        run_job("ident", 1'b1, 1, 0, 0);

        run_job("pause", 1'b1, 1, 3, 5);

        clear_ops();
        for (int e = 2; e < 64; e++) set_a(e, 9, e % 16, 0, 4'b1110);
        set_a(0, 3, 2, 0, 4'b0001);
        set_a(1, -2, 2, 1, 4'b1111);
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++) set_b(k, n, k * 3 - n);
        for (int n = 0; n < N; n++) begin
            set_b(0, n, 5);
            set_b(1, n, 4);
        end
        all_rows(0);
        exp_rows[2] = row_fill(7);
        run_job("same_row", 1'b1, 1, 0, 0);

        clear_ops();
        for (int e = 0; e < 16; e++) set_a(e, 127, 0, 0, 4'b0001);
        for (int n = 0; n < N; n++) set_b(0, n, 127);
        all_rows(0);
        exp_rows[0] = row_fill(127);
        run_job("sat_pos", 1'b1, 1, 0, 0);

        for (int n = 0; n < N; n++) set_b(0, n, -127);
        exp_rows[0] = row_fill(-128);
        run_job("sat_neg", 1'b1, 1, 0, 0);

        clear_ops();
        for (int e = 0; e < 128; e++) set_a(e, 1, e % 16, 0, 4'b0001);
        for (int n = 0; n < N; n++) set_b(0, n, 1);
        all_rows(4);
        run_job("blk4", 1'b1, 4, 0, 0);

        all_rows(8);
        run_job("blk8", 1'b1, 8, 0, 0);

        all_rows(0);
        run_job("blk0", 1'b1, 0, 0, 0);

        setup_identity();
        run_job("ident2", 1'b1, 1, 0, 0);

        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        compute_en = 1'b1;
        num_blocks = 4'd2;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset_mid_out", out, '0);
        @(negedge clk);
        reset = 1'b0;
        compute_en = 1'b0;
        @(negedge clk);

        all_rows(0);
        run_job("post_reset_noload", 1'b0, 1, 0, 0);

        setup_identity();
        run_job("post_reset_ident", 1'b1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
